pipe_dest_tracker: RTL and testbench

Tracks in-flight destination registers through the ID/EX, EX/MEM and MEM/WB pipeline stages of the 5-stage core. It produces the destination-register and RegWrite fields that the forwarding unit consumes. It detects load-use hazards and stalls the ID stage, and it counts stall cycles. It sits between the ID stage and the forwarding unit and updates its registered stage state every clock.

---
 rtl/pipe_dest_tracker.sv | 135 +++++++++++++
 tb/tb_pipe_dest_tracker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_dest_tracker.sv
// pipe_dest_tracker: tracks destination registers through the ID/EX, EX/MEM
// and MEM/WB stages for the forwarding unit. It also detects load-use hazards,
// stalls ID when one is found, and counts the load-use stall cycles.
module pipe_dest_tracker #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_reg_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic [4:0]       id_reg_rs,
    input  logic [4:0]       id_reg_rt,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             id_stall,
    output logic [4:0]       id_ex_reg_rd,
    output logic [4:0]       ex_mem_reg_rd,
    output logic [4:0]       mem_wb_reg_rd,
    output logic             ex_mem_reg_write,
    output logic             mem_wb_reg_write,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned REG_W = 5;

    // Stage state. The load flag only matters while the instruction is in ID/EX.
    logic             idex_valid_q, idex_wr_q, idex_ld_q;
    logic [REG_W-1:0] idex_rd_q;
    logic             exmem_valid_q, exmem_wr_q;
    logic [REG_W-1:0] exmem_rd_q;
    logic             memwb_valid_q, memwb_wr_q;
    logic [REG_W-1:0] memwb_rd_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             idex_valid_d, idex_wr_d, idex_ld_d;
    logic [REG_W-1:0] idex_rd_d;
    logic             exmem_valid_d, exmem_wr_d;
    logic [REG_W-1:0] exmem_rd_d;
    logic             memwb_valid_d, memwb_wr_d;
    logic [REG_W-1:0] memwb_rd_d;
    logic [CNT_W-1:0] stall_cnt_d;

    logic             lu;
    logic             id_wr;

    // Hazard detection and next-state selection, mem_stall > flush > load-use > advance.
    always_comb begin
        idex_valid_d  = idex_valid_q;
        idex_wr_d     = idex_wr_q;
        idex_ld_d     = idex_ld_q;
        idex_rd_d     = idex_rd_q;
        exmem_valid_d = exmem_valid_q;
        exmem_wr_d    = exmem_wr_q;
        exmem_rd_d    = exmem_rd_q;
        memwb_valid_d = memwb_valid_q;
        memwb_wr_d    = memwb_wr_q;
        memwb_rd_d    = memwb_rd_q;
        stall_cnt_d   = stall_cnt_q;

        lu    = id_valid && idex_valid_q && idex_ld_q && idex_wr_q &&
                ((idex_rd_q == id_reg_rs) || (idex_rd_q == id_reg_rt));
        id_wr = id_reg_write && (id_reg_rd != REG_W'(0));

        if (mem_stall) begin
            // Frozen pipeline; a redirect still has to kill the ID/EX instruction.
            if (flush) begin
                idex_valid_d = 1'b0;
                idex_wr_d    = 1'b0;
                idex_ld_d    = 1'b0;
                idex_rd_d    = REG_W'(0);
            end
        end else begin
            exmem_valid_d = idex_valid_q;
            exmem_wr_d    = idex_wr_q;
            exmem_rd_d    = idex_rd_q;
            memwb_valid_d = exmem_valid_q;
            memwb_wr_d    = exmem_wr_q;
            memwb_rd_d    = exmem_rd_q;
            if (flush || lu) begin
                idex_valid_d = 1'b0;
                idex_wr_d    = 1'b0;
                idex_ld_d    = 1'b0;
                idex_rd_d    = REG_W'(0);
            end else begin
                idex_valid_d = id_valid;
                idex_wr_d    = id_wr;
                idex_ld_d    = id_mem_read;
                idex_rd_d    = id_reg_rd;
            end
            if (lu && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Stage and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid_q  <= 1'b0;
            idex_wr_q     <= 1'b0;
            idex_ld_q     <= 1'b0;
            idex_rd_q     <= REG_W'(0);
            exmem_valid_q <= 1'b0;
            exmem_wr_q    <= 1'b0;
            exmem_rd_q    <= REG_W'(0);
            memwb_valid_q <= 1'b0;
            memwb_wr_q    <= 1'b0;
            memwb_rd_q    <= REG_W'(0);
            stall_cnt_q   <= CNT_W'(0);
        end else begin
            idex_valid_q  <= idex_valid_d;
            idex_wr_q     <= idex_wr_d;
            idex_ld_q     <= idex_ld_d;
            idex_rd_q     <= idex_rd_d;
            exmem_valid_q <= exmem_valid_d;
            exmem_wr_q    <= exmem_wr_d;
            exmem_rd_q    <= exmem_rd_d;
            memwb_valid_q <= memwb_valid_d;
            memwb_wr_q    <= memwb_wr_d;
            memwb_rd_q    <= memwb_rd_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign id_stall         = mem_stall | (lu & ~flush);
    assign id_ex_reg_rd     = idex_rd_q;
    assign ex_mem_reg_rd    = exmem_rd_q;
    assign mem_wb_reg_rd    = memwb_rd_q;
    assign ex_mem_reg_write = exmem_valid_q & exmem_wr_q;
    assign mem_wb_reg_write = memwb_valid_q & memwb_wr_q;
    assign stall_count      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Bench for pipe_dest_tracker: directed test-plan scenarios with literal
// expectations, then randomized traffic against a behavioural pipeline model.
module tb_pipe_dest_tracker;

    localparam int unsigned CNT_W = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid, id_reg_write, id_mem_read, mem_stall, flush;
    logic [4:0]       id_reg_rd, id_reg_rs, id_reg_rt;
    logic             id_stall, ex_mem_reg_write, mem_wb_reg_write;
    logic [4:0]       id_ex_reg_rd, ex_mem_reg_rd, mem_wb_reg_rd;
    logic [CNT_W-1:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    pipe_dest_tracker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_reg_rd(id_reg_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_reg_rs(id_reg_rs), .id_reg_rt(id_reg_rt),
        .mem_stall(mem_stall), .flush(flush), .id_stall(id_stall),
        .id_ex_reg_rd(id_ex_reg_rd), .ex_mem_reg_rd(ex_mem_reg_rd),
        .mem_wb_reg_rd(mem_wb_reg_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_reg_write(mem_wb_reg_write), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB; an instruction is a record
    // that slides down the array unless memory stalls.
    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } instr_t;

    instr_t pipe [3];
    int unsigned m_cnt;

    function automatic instr_t bubble();
        instr_t b;
        b.v = 1'b0; b.rd = 5'd0; b.wr = 1'b0; b.ld = 1'b0;
        return b;
    endfunction

    function automatic logic model_lu();
        return id_valid && pipe[0].v && pipe[0].ld && pipe[0].wr &&
               (pipe[0].rd == id_reg_rs || pipe[0].rd == id_reg_rt);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = bubble();
            m_cnt = 0;
        end else begin
            logic   hz;
            instr_t inc;
            hz = model_lu();
            if (mem_stall) begin
                if (flush) pipe[0] = bubble();
            end else begin
                inc.v  = id_valid;
                inc.rd = id_reg_rd;
                inc.wr = id_reg_write && (id_reg_rd != 5'd0);
                inc.ld = id_mem_read;
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = (flush || hz) ? bubble() : inc;
                if (hz && !flush && m_cnt < CNT_MAX) m_cnt++;
            end
        end
    end

    // Single compare process, mid-cycle, every cycle once enabled.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("id_stall",         32'(id_stall),         32'(mem_stall | (model_lu() & ~flush)));
            chk("id_ex_reg_rd",     32'(id_ex_reg_rd),     32'(pipe[0].rd));
            chk("ex_mem_reg_rd",    32'(ex_mem_reg_rd),    32'(pipe[1].rd));
            chk("mem_wb_reg_rd",    32'(mem_wb_reg_rd),    32'(pipe[2].rd));
            chk("ex_mem_reg_write", 32'(ex_mem_reg_write), 32'(pipe[1].v & pipe[1].wr));
            chk("mem_wb_reg_write", 32'(mem_wb_reg_write), 32'(pipe[2].v & pipe[2].wr));
            chk("stall_count",      32'(stall_count),      m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [4:0] rd, input logic w, input logic ld,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic ms, input logic fl);
        id_valid = v; id_reg_rd = rd; id_reg_write = w; id_mem_read = ld;
        id_reg_rs = rs; id_reg_rt = rt; mem_stall = ms; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle async reset, released just after an edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_idex_rd"},  32'(id_ex_reg_rd),     0);
        chk({tag, "_exmem_rd"}, 32'(ex_mem_reg_rd),    0);
        chk({tag, "_memwb_rd"}, 32'(mem_wb_reg_rd),    0);
        chk({tag, "_exmem_wr"}, 32'(ex_mem_reg_write), 0);
        chk({tag, "_memwb_wr"}, 32'(mem_wb_reg_write), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        chk_all_zero("reset");
        chk("reset_count", 32'(stall_count), 0);
        chk("reset_stall", 32'(id_stall), 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Single writer travels through all three stages.
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick(); idle();
        chk("lat_idex", 32'(id_ex_reg_rd), 5);
        tick();
        chk("lat_exmem", 32'(ex_mem_reg_rd), 5);
        chk("lat_exmem_wr", 32'(ex_mem_reg_write), 1);
        tick();
        chk("lat_memwb", 32'(mem_wb_reg_rd), 5);
        chk("lat_memwb_wr", 32'(mem_wb_reg_write), 1);
        tick();
        chk_all_zero("lat_gone");

        // Load rd=7 followed by a consumer of r7.
        do_reset();
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 1'b0, 1'b0);
        #1 chk("lu_stall_c1", 32'(id_stall), 1);
        tick();
        #1 chk("lu_stall_c2", 32'(id_stall), 0);
        chk("lu_bubble", 32'(id_ex_reg_rd), 0);
        chk("lu_count", 32'(stall_count), 1);
        tick(); idle();
        chk("lu_consumer", 32'(id_ex_reg_rd), 8);
        chk("lu_load_wb", 32'(mem_wb_reg_rd), 7);
        tick();

        // Load to x0 never hazards and never reports a write.
        do_reset();
        drive(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1 chk("x0_nostall", 32'(id_stall), 0);
        tick(); idle();
        chk("x0_count", 32'(stall_count), 0);
        chk("x0_exmem_wr", 32'(ex_mem_reg_write), 0);
        tick();
        chk("x0_memwb_wr", 32'(mem_wb_reg_write), 0);

        // Fill the pipe then freeze it with mem_stall for three cycles.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'(i), 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
            #1 chk("ms_stall", 32'(id_stall), 1);
            tick();
            chk("ms_idex", 32'(id_ex_reg_rd), 3);
            chk("ms_exmem", 32'(ex_mem_reg_rd), 2);
            chk("ms_memwb", 32'(mem_wb_reg_rd), 1);
            chk("ms_memwb_wr", 32'(mem_wb_reg_write), 1);
        end
        drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick(); idle();
        chk("ms_resume_idex", 32'(id_ex_reg_rd), 4);
        chk("ms_resume_exmem", 32'(ex_mem_reg_rd), 3);
        chk("ms_resume_memwb", 32'(mem_wb_reg_rd), 2);
        chk("ms_count", 32'(stall_count), 0);

        // Flush wins over a load-use hazard.
        do_reset();
        drive(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd2, 1'b1, 1'b0, 5'd9, 5'd0, 1'b0, 1'b1);
        #1 chk("fl_nostall", 32'(id_stall), 0);
        tick(); idle();
        chk("fl_bubble", 32'(id_ex_reg_rd), 0);
        chk("fl_load_adv", 32'(ex_mem_reg_rd), 9);
        chk("fl_count", 32'(stall_count), 0);

        // Five load-use stalls saturate a 2-bit counter at 3.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd10, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
            tick();
            drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd10, 5'd0, 1'b0, 1'b0);
            tick();
            tick();
        end
        idle();
        chk("sat_count", 32'(stall_count), 3);
        tick();
        chk("sat_hold", 32'(stall_count), 3);

        // Async reset between edges clears outputs without a clock edge.
        drive(1'b1, 5'd11, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd11, 5'd0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async");
        chk("async_count", 32'(stall_count), 0);
        chk("async_stall", 32'(id_stall), 1);
        idle();
        tick();
        rst_n = 1'b1;

        // Randomized traffic on a small register set to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                drive(1'($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 9) == 0));
                tick();
            end
        end

        idle();
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
